ifetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the pipeline datapath.
- Owns the fetch PC and issues requests to a pipelined instruction memory (req/gnt, then rvalid some cycles later).
- Buffers returned instructions, tagged with their PC, in a small FIFO and presents them to the datapath's IF/ID input through a valid/ready handshake.
- On a branch/jump redirect from EX it flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifetch_queue_if.sv | 35 +++
 rtl/ifetch_queue.sv | 153 +++++++++++++++
 tb/tb_ifetch_queue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory request/response, branch redirect and
// fetch-queue handshake signals of the instruction-fetch front end.
// master = the fetch unit (ifetch_queue); slave = its environment.
interface ifetch_queue_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32
);
  logic                  imem_req;
  logic [ADDR_SIZE-1:0]  imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INSTR_SIZE-1:0] imem_rdata;
  logic                  redirect;
  logic [ADDR_SIZE-1:0]  redirect_pc;
  logic                  fq_valid;
  logic                  fq_ready;
  logic [INSTR_SIZE-1:0] fq_instr;
  logic [ADDR_SIZE-1:0]  fq_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output fq_valid, fq_instr, fq_pc,
    input  fq_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  fq_valid, fq_instr, fq_pc,
    output fq_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end. Owns the fetch PC, issues
// credit-limited requests to a pipelined instruction memory, tags each
// request with its PC, buffers returned {pc, instr} pairs in a small FIFO and
// hands them to IF/ID over a valid/ready handshake. A redirect from EX
// flushes the FIFO and marks every in-flight response as stale.
// Optional build macro IFETCH_QUEUE_BYPASS_EN: a response arriving while the
// FIFO is empty is presented on fq_* in the same cycle (and skips the FIFO
// when accepted). Without it fq_* depend only on registered state.
module ifetch_queue #(
  parameter int                   DEPTH           = 4,
  parameter int                   MAX_OUTSTANDING = 2,
  parameter int                   ADDR_SIZE       = 32,
  parameter int                   INSTR_SIZE      = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC        = '0
) (
  input logic            clk,
  input logic            reset,
  ifetch_queue_if.master bus
);
  localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(32'h0000_0013);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  // Fetch state and credit counters.
  logic [ADDR_SIZE-1:0]  fetchPc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         discard;

  // In-order PC tags of issued requests.
  logic [ADDR_SIZE-1:0]  tagMem [MAX_OUTSTANDING];
  logic [TW-1:0]         tagWr;
  logic [TW-1:0]         tagRd;

  // Fetch queue of {pc, instr}.
  logic [ADDR_SIZE-1:0]  pcMem    [DEPTH];
  logic [INSTR_SIZE-1:0] instrMem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [CW-1:0]         count;

  logic                  issue;
  logic                  bypass;
  logic                  doPush;
  logic                  doPop;
  logic [ADDR_SIZE-1:0]  respPc;

  // A request goes out only when a FIFO slot is reserved for its response,
  // so imem_req never depends on fq_ready.
  assign bus.imem_req  = !reset && !bus.redirect && (outstanding < MAX_OUT) &&
                         ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
  assign bus.imem_addr = fetchPc;
  assign issue         = bus.imem_req && bus.imem_gnt;
  assign respPc        = tagMem[tagRd];

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && (discard == '0) && !bus.redirect && bus.imem_rvalid;
`else
  assign bypass = 1'b0;
`endif

  // Live responses are queued unless consumed straight off the bypass path;
  // the head is only removed outside a redirect, which clears the queue.
  assign doPush = bus.imem_rvalid && (discard == '0) && !bus.redirect &&
                  !(bypass && bus.fq_ready);
  assign doPop  = (count != '0) && bus.fq_ready && !bus.redirect;

  // Head presentation: FIFO head, else a bypassed response, else NOP/0.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    bus.fq_valid = 1'b0;
    bus.fq_instr = NOP;
    bus.fq_pc    = '0;
    if (count != '0) begin
      bus.fq_valid = 1'b1;
      bus.fq_instr = instrMem[rdPtr];
      bus.fq_pc    = pcMem[rdPtr];
    end else if (bypass) begin
      bus.fq_valid = 1'b1;
      bus.fq_instr = bus.imem_rdata;
      bus.fq_pc    = respPc;
    end
  end

  // Fetch PC, in-flight/stale counters and queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      tagWr       <= '0;
      tagRd       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (issue)
        tagWr <= (tagWr == TAG_LAST) ? '0 : tagWr + TW'(1);
      if (bus.imem_rvalid)
        tagRd <= (tagRd == TAG_LAST) ? '0 : tagRd + TW'(1);

      case ({issue, bus.imem_rvalid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase

      if (bus.redirect) begin
        // No issue happens this cycle, so everything still in flight after
        // this cycle's response (which is dropped) is stale.
        fetchPc <= {bus.redirect_pc[ADDR_SIZE-1:2], 2'b00};
        discard <= outstanding - OW'(bus.imem_rvalid);
        wrPtr   <= '0;
        rdPtr   <= '0;
        count   <= '0;
      end else begin
        if (issue)
          fetchPc <= fetchPc + ADDR_SIZE'(4);
        if (bus.imem_rvalid && (discard != '0))
          discard <= discard - OW'(1);
        if (doPush)
          wrPtr <= wrPtr + PW'(1);
        if (doPop)
          rdPtr <= rdPtr + PW'(1);
        if (doPush && !doPop)
          count <= count + CW'(1);
        else if (!doPush && doPop)
          count <= count - CW'(1);
      end
    end
  end

  // Tag and queue payload storage.
  // NOTE: storage arrays are not reset; counters and pointers guard every read.
  always_ff @(posedge clk) begin
    if (issue)
      tagMem[tagWr] <= fetchPc;
    if (doPush) begin
      pcMem[wrPtr]    <= respPc;
      instrMem[wrPtr] <= bus.imem_rdata;
    end
  end

  // The credit rule leaves a free slot for every live response.
  assert property (@(posedge clk) disable iff (reset) !(doPush && (count == FULL)));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue. A behavioural imem
// answers granted requests in order; every grant pushes the expected
// {pc, instr} to a scoreboard queue, a redirect empties it, and every
// fq handshake pops and compares.
module tb_ifetch_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam int FILL_LAT = 1;
`else
  localparam int FILL_LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;

  ifetch_queue_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) bus ();

  ifetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .ADDR_SIZE(32), .INSTR_SIZE(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          passCnt = 0;
  int          totalCnt = 0;
  fetchEntry_t expQ[$];
  logic [31:0] pend[$];
  logic [31:0] modelPc;
  logic        gntEn, respEn;
  logic        gntSeen, popSeen, validSeen;
  logic [31:0] lastGntAddr, lastPopPc;
  int          grantCnt, popCnt;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic setIdle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.fq_ready    = 1'b0;
    gntEn           = 1'b0;
    respEn          = 1'b0;
  endtask

  task automatic clearModel();
    expQ.delete();
    pend.delete();
    modelPc  = 32'h0;
    grantCnt = 0;
    popCnt   = 0;
  endtask

  // One clock: drive imem at the falling edge, observe what the coming rising
  // edge will do, update the scoreboard, return at the next falling edge.
  task automatic cycle();
    fetchEntry_t e;
    bus.imem_rvalid = respEn && (pend.size() > 0);
    bus.imem_rdata  = bus.imem_rvalid ? instrOf(pend[0]) : 32'h0;
    bus.imem_gnt    = gntEn;
    #1;
    gntSeen   = bus.imem_req && bus.imem_gnt;
    validSeen = bus.fq_valid;
    popSeen   = 1'b0;
    if (bus.redirect) begin
      totalCnt++;
      if (bus.imem_req !== 1'b0)
        $display("FAIL redirect_req: got imem_req=%b want 0", bus.imem_req);
      else passCnt++;
    end
    if (gntSeen) begin
      totalCnt++;
      if (bus.imem_addr !== modelPc)
        $display("FAIL issue_addr: got %h want %h", bus.imem_addr, modelPc);
      else passCnt++;
      expQ.push_back('{pc: modelPc, instr: instrOf(modelPc)});
      pend.push_back(bus.imem_addr);
      lastGntAddr = bus.imem_addr;
      grantCnt++;
      modelPc = modelPc + 32'd4;
    end
    if (bus.imem_rvalid) void'(pend.pop_front());
    if (bus.redirect) begin
      expQ.delete();
      modelPc = {bus.redirect_pc[31:2], 2'b00};
    end else if (bus.fq_valid && bus.fq_ready) begin
      popSeen   = 1'b1;
      lastPopPc = bus.fq_pc;
      popCnt++;
      totalCnt++;
      if (expQ.size() == 0)
        $display("FAIL sb_pop: got unexpected pc=%h instr=%h want no entry", bus.fq_pc, bus.fq_instr);
      else begin
        e = expQ.pop_front();
        if (bus.fq_pc !== e.pc || bus.fq_instr !== e.instr)
          $display("FAIL sb_pop: got pc=%h instr=%h want pc=%h instr=%h",
                   bus.fq_pc, bus.fq_instr, e.pc, e.instr);
        else passCnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIdle();
    clearModel();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitPop(output bit found);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (popSeen) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setIdle();
    clearModel();
    @(negedge clk);
    totalCnt++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passCnt++;
    totalCnt++; if (bus.fq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.fq_valid); else passCnt++;
    totalCnt++; if (bus.fq_instr !== NOP) $display("FAIL reset_instr: got %h want %h", bus.fq_instr, NOP); else passCnt++;
    totalCnt++; if (bus.fq_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.fq_pc); else passCnt++;
    totalCnt++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.imem_addr); else passCnt++;
    reset = 1'b0;
    #1;
    totalCnt++; if (bus.imem_req !== 1'b1) $display("FAIL release_req: got %b want 1", bus.imem_req); else passCnt++;
  endtask

  task automatic test_stream();
    int firstGnt = -1;
    int firstValid = -1;
    int steady = 0;
    doReset();
    bus.fq_ready = 1'b1; gntEn = 1'b1; respEn = 1'b1;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (gntSeen && firstGnt < 0) firstGnt = k;
      if (validSeen && firstValid < 0) firstValid = k;
      if (k >= 6 && validSeen) steady++;
    end
    totalCnt++; if (firstGnt !== 0) $display("FAIL stream_first_gnt: got cycle %0d want 0", firstGnt); else passCnt++;
    totalCnt++; if (firstValid - firstGnt !== FILL_LAT) $display("FAIL stream_latency: got %0d want %0d", firstValid - firstGnt, FILL_LAT); else passCnt++;
    totalCnt++; if (steady !== 8) $display("FAIL stream_throughput: got %0d valid cycles want 8", steady); else passCnt++;
    totalCnt++; if (popCnt !== 14 - FILL_LAT) $display("FAIL stream_pops: got %0d want %0d", popCnt, 14 - FILL_LAT); else passCnt++;
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    doReset();
    gntEn = 1'b1; respEn = 1'b1;
    repeat (10) cycle();
    totalCnt++; if (grantCnt !== 4) $display("FAIL bp_grants: got %0d want 4", grantCnt); else passCnt++;
    totalCnt++; if (bus.imem_req !== 1'b0) $display("FAIL bp_req_held: got %b want 0", bus.imem_req); else passCnt++;
    totalCnt++; if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h0) $display("FAIL bp_head: got valid=%b pc=%h want 1/0", bus.fq_valid, bus.fq_pc); else passCnt++;
    bus.fq_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (gntSeen) found = 1'b1;
    end
    totalCnt++; if (!found || lastGntAddr !== 32'h10) $display("FAIL bp_resume_addr: got %h (seen=%0d) want 00000010", lastGntAddr, found); else passCnt++;
    totalCnt++; if (popCnt !== 2) $display("FAIL bp_resume_pops: got %0d want 2", popCnt); else passCnt++;
    repeat (8) cycle();
  endtask

  task automatic test_redirect_flush();
    bit found;
    doReset();
    gntEn = 1'b1; respEn = 1'b1;
    repeat (3) cycle();
    respEn = 1'b0;
    cycle();
    totalCnt++; if (lastGntAddr !== 32'hC || pend.size() !== 2) $display("FAIL flush_setup: got last=%h inflight=%0d want 0000000c/2", lastGntAddr, pend.size()); else passCnt++;
    totalCnt++; if (bus.fq_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", bus.fq_valid); else passCnt++;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    cycle();
    bus.redirect = 1'b0;
    totalCnt++; if (bus.fq_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.fq_valid); else passCnt++;
    totalCnt++; if (bus.imem_addr !== 32'h100) $display("FAIL flush_addr: got %h want 00000100", bus.imem_addr); else passCnt++;
    bus.fq_ready = 1'b1; respEn = 1'b1;
    waitPop(found);
    totalCnt++; if (!found || lastPopPc !== 32'h100) $display("FAIL flush_first_pc: got %h (seen=%0d) want 00000100", lastPopPc, found); else passCnt++;
    repeat (4) cycle();
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    doReset();
    bus.fq_ready = 1'b1; gntEn = 1'b1; respEn = 1'b1;
    repeat (2) cycle();
    respEn = 1'b0;
    cycle();
    respEn = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    totalCnt++; if (pend.size() !== 2 || pend[0] !== 32'h4) $display("FAIL rv_setup: got inflight=%0d want 2 with 00000004 first", pend.size()); else passCnt++;
    cycle();
    bus.redirect = 1'b0;
    waitPop(found);
    totalCnt++; if (!found || lastPopPc !== 32'h200) $display("FAIL rv_first_pc: got %h (seen=%0d) want 00000200", lastPopPc, found); else passCnt++;
    repeat (4) cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[2];
    int n = 0;
    doReset();
    bus.fq_ready = 1'b1; gntEn = 1'b1; respEn = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    cycle();
    bus.redirect = 1'b0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      cycle();
      if (gntSeen) begin
        addrs[n] = lastGntAddr;
        n++;
      end
    end
    totalCnt++; if (n !== 2 || addrs[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_first: got %h (n=%0d) want fffffffc", addrs[0], n); else passCnt++;
    totalCnt++; if (n !== 2 || addrs[1] !== 32'h0) $display("FAIL wrap_second: got %h (n=%0d) want 00000000", addrs[1], n); else passCnt++;
    repeat (6) cycle();
  endtask

  task automatic test_async_reset();
    bit found;
    doReset();
    gntEn = 1'b1; respEn = 1'b1;
    repeat (2) cycle();
    respEn = 1'b0;
    cycle();
    totalCnt++; if (bus.fq_valid !== 1'b1 || pend.size() !== 2) $display("FAIL ar_setup: got valid=%b inflight=%0d want 1/2", bus.fq_valid, pend.size()); else passCnt++;
    #2 reset = 1'b1;
    #1;
    totalCnt++; if (bus.imem_req !== 1'b0) $display("FAIL ar_req: got %b want 0", bus.imem_req); else passCnt++;
    totalCnt++; if (bus.fq_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", bus.fq_valid); else passCnt++;
    totalCnt++; if (bus.fq_instr !== NOP || bus.fq_pc !== 32'h0) $display("FAIL ar_head: got instr=%h pc=%h want %h/0", bus.fq_instr, bus.fq_pc, NOP); else passCnt++;
    totalCnt++; if (bus.imem_addr !== 32'h0) $display("FAIL ar_addr: got %h want 0", bus.imem_addr); else passCnt++;
    setIdle();
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    bus.fq_ready = 1'b1; gntEn = 1'b1; respEn = 1'b1;
    waitPop(found);
    totalCnt++; if (!found || lastPopPc !== 32'h0) $display("FAIL ar_post_pc: got %h (seen=%0d) want 00000000", lastPopPc, found); else passCnt++;
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_rvalid();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
